tile_loader: RTL and testbench

// - Sequencer directly upstream of the banked memory model. Loads one N x N tile (weights W or activations X) and emits it as N row vectors to the systolic-array feeder.
// - Issues one non-pipelined read at a time and waits a fixed MEM_LATENCY for each read, because memory has no response-valid signal.
// - Packs BANKING_FACTOR-wide beats into N-element rows.
// - Output uses a valid/ready handshake.

---
 rtl/tpu_mem_pkg.sv | 24 ++
 rtl/tile_loader_if.sv | 37 +++
 rtl/row_pack_buf.sv | 33 +++
 rtl/tile_loader.sv | 169 ++++++++++++++++
 tb/tb_tile_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_mem_pkg.sv
// Shared types and helpers for the tile loader and its memory-side neighbours:
// loader state encoding, default tile base addresses and the beat address helper.
package tpu_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } tile_loader_state_e;

  localparam logic [12:0] TPU_BASE_ADDR_W = 13'h0000;
  localparam logic [12:0] TPU_BASE_ADDR_X = 13'h1000;

  // Byte address of a beat; callers truncate to their address width so it wraps.
  function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                            input logic [31:0] beat,
                                            input logic [31:0] bytes_per_beat);
    return base + beat * bytes_per_beat;
  endfunction

endpackage

// File: rtl/tile_loader_if.sv
// Memory request/response bus plus the row-output handshake of the tile loader.
// Row handshake: a row transfers on any cycle with row_valid && row_ready; once
// row_valid rises, row_valid, row_data and row_idx hold until that cycle.
interface tile_loader_if #(
  parameter int N              = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH  = 13
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                                mem_read_en;
  logic [ADDRESS_WIDTH-1:0]            mem_req_addr;
  logic                                mem_write_en;
  logic [DATA_WIDTH*BANKING_FACTOR-1:0] mem_req_data;
  logic [DATA_WIDTH*BANKING_FACTOR-1:0] mem_resp_data;

  logic                                row_valid;
  logic                                row_ready;
  logic [N*DATA_WIDTH-1:0]             row_data;
  logic [IDX_W-1:0]                    row_idx;

  modport master (
    output mem_read_en, mem_req_addr, mem_write_en, mem_req_data,
    input  mem_resp_data,
    output row_valid, row_data, row_idx,
    input  row_ready
  );

  modport slave (
    input  mem_read_en, mem_req_addr, mem_write_en, mem_req_data,
    output mem_resp_data,
    input  row_valid, row_data, row_idx,
    output row_ready
  );

endinterface

// File: rtl/row_pack_buf.sv
// N-element row register file: beats of BANKING_FACTOR elements are written at a
// slot index and the whole row is presented in parallel.
module row_pack_buf #(
  parameter int N              = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int BANKING_FACTOR = 1,
  parameter int SLOT_W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [SLOT_W-1:0]                    wr_slot,
  input  logic [DATA_WIDTH*BANKING_FACTOR-1:0] wr_data,
  output logic [N*DATA_WIDTH-1:0]              row_data
);

  logic [DATA_WIDTH-1:0] elems_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) elems_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BANKING_FACTOR; b++)
        elems_q[int'(wr_slot) + b] <= wr_data[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    row_data = '0;
    for (int c = 0; c < N; c++) row_data[c*DATA_WIDTH +: DATA_WIDTH] = elems_q[c];
  end

endmodule

// File: rtl/tile_loader.sv
// Loads one N x N tile with single outstanding fixed-latency reads and emits it row
// by row. Optional busy/stall counters are built when TILE_LOADER_PERF_EN is defined.
module tile_loader
  import tpu_mem_pkg::*;
#(
  parameter int                       N              = 4,
  parameter int                       DATA_WIDTH     = 16,
  parameter int                       BANKING_FACTOR = 1,
  parameter int                       ADDRESS_WIDTH  = 13,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_W    = ADDRESS_WIDTH'(TPU_BASE_ADDR_W),
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR_X    = ADDRESS_WIDTH'(TPU_BASE_ADDR_X),
  parameter int                       MEM_LATENCY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sel_x,
  output logic               busy,
  output logic               done,
  output tile_loader_state_e dbg_state,
  tile_loader_if.master      bus
`ifdef TILE_LOADER_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stall
`endif
);

  localparam int BPR            = N / BANKING_FACTOR;
  localparam int BEATS          = N * BPR;
  localparam int BYTES_PER_BEAT = BANKING_FACTOR * (DATA_WIDTH / 8);
  localparam int IDX_W          = (N > 1) ? $clog2(N) : 1;
  localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  if ((N % BANKING_FACTOR) != 0 || MEM_LATENCY < 1) begin : g_param_check
    $error("tile_loader: N must be a multiple of BANKING_FACTOR and MEM_LATENCY >= 1");
  end

  tile_loader_state_e       state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [IDX_W-1:0]         row_q, row_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic                     buf_wr;
  logic [IDX_W-1:0]         wr_slot;
  logic                     last_beat_in_row;
  logic [ADDRESS_WIDTH-1:0] req_addr;

  always_comb begin
    wr_slot          = IDX_W'((int'(beat_q) % BPR) * BANKING_FACTOR);
    last_beat_in_row = (int'(beat_q) % BPR) == (BPR - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      row_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      wait_q  <= wait_d;
    end
  end

  // One request in flight at most: the next ISSUE only follows CAPTURE of the previous beat.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    row_d   = row_q;
    wait_d  = wait_q;
    buf_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = sel_x ? BASE_ADDR_X : BASE_ADDR_W;
          beat_d  = '0;
          row_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(MEM_LATENCY - 1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        buf_wr  = 1'b1;
        beat_d  = beat_q + 1'b1;
        state_d = last_beat_in_row ? ST_EMIT : ST_ISSUE;
      end
      ST_EMIT: begin
        if (bus.row_ready) begin
          row_d   = row_q + 1'b1;
          state_d = (row_q == IDX_W'(N - 1)) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign req_addr = ADDRESS_WIDTH'(beat_addr(32'(base_q), 32'(beat_q), 32'(BYTES_PER_BEAT)));

  assign busy             = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                            (state_q == ST_CAPTURE) || (state_q == ST_EMIT);
  assign done             = (state_q == ST_DONE);
  assign dbg_state        = state_q;
  assign bus.mem_read_en  = (state_q == ST_ISSUE);
  assign bus.mem_req_addr = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? req_addr : '0;
  assign bus.mem_write_en = 1'b0;
  assign bus.mem_req_data = '0;
  assign bus.row_valid    = (state_q == ST_EMIT);
  assign bus.row_idx      = row_q;

  row_pack_buf #(
    .N              (N),
    .DATA_WIDTH     (DATA_WIDTH),
    .BANKING_FACTOR (BANKING_FACTOR),
    .SLOT_W         (IDX_W)
  ) u_row_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr),
    .wr_slot  (wr_slot),
    .wr_data  (bus.mem_resp_data),
    .row_data (bus.row_data)
  );

`ifdef TILE_LOADER_PERF_EN
  logic [31:0] cyc_cnt_q, stall_cnt_q, perf_cycles_q, perf_stall_q;

  // Running counters restart every idle period; results are published in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        cyc_cnt_q   <= '0;
        stall_cnt_q <= '0;
      end else if (busy) begin
        if (cyc_cnt_q != '1) cyc_cnt_q <= cyc_cnt_q + 32'd1;
        if (state_q == ST_EMIT && !bus.row_ready && stall_cnt_q != '1)
          stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (state_q == ST_DONE) begin
        perf_cycles_q <= cyc_cnt_q;
        perf_stall_q  <= stall_cnt_q;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_tile_loader.sv
// Bench for tile_loader: a BF=1 and a BF=2 instance, each behind a fixed-latency
// memory whose word at byte address a holds a/2 (the element index).
module tb_tile_loader;
  import tpu_mem_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 13;
  localparam int L  = 2;
  localparam int IW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT 1 (BF=1) ----------------
  logic start = 1'b0, sel_x = 1'b0, busy, done;
  tile_loader_state_e dbg_state;
  tile_loader_if #(.N(N), .DATA_WIDTH(DW), .BANKING_FACTOR(1), .ADDRESS_WIDTH(AW)) bus1 ();
`ifdef TILE_LOADER_PERF_EN
  logic [31:0] perf_cycles1, perf_stall1, perf_cycles2, perf_stall2;
`endif

  tile_loader #(.N(N), .DATA_WIDTH(DW), .BANKING_FACTOR(1), .ADDRESS_WIDTH(AW), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_x(sel_x), .busy(busy), .done(done),
    .dbg_state(dbg_state), .bus(bus1)
`ifdef TILE_LOADER_PERF_EN
    , .perf_cycles(perf_cycles1), .perf_stall(perf_stall1)
`endif
  );

  // ---------------- DUT 2 (BF=2) ----------------
  logic start2 = 1'b0, sel2 = 1'b0, busy2, done2;
  tile_loader_state_e dbg_state2;
  tile_loader_if #(.N(N), .DATA_WIDTH(DW), .BANKING_FACTOR(2), .ADDRESS_WIDTH(AW)) bus2 ();

  tile_loader #(.N(N), .DATA_WIDTH(DW), .BANKING_FACTOR(2), .ADDRESS_WIDTH(AW), .MEM_LATENCY(L)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sel_x(sel2), .busy(busy2), .done(done2),
    .dbg_state(dbg_state2), .bus(bus2)
`ifdef TILE_LOADER_PERF_EN
    , .perf_cycles(perf_cycles2), .perf_stall(perf_stall2)
`endif
  );

  // ---------------- memory models ----------------
  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return DW'(a >> 1);
  endfunction

  logic [AW-1:0] pa1 [L];
  logic          pv1 [L] = '{default: 1'b0};
  logic [AW-1:0] pa2 [L];
  logic          pv2 [L] = '{default: 1'b0};

  // Response is only meaningful in the cycle after edge E_L; other cycles carry noise.
  always @(posedge clk) begin
    pa1[0] <= bus1.mem_req_addr;
    pv1[0] <= bus1.mem_read_en;
    pa2[0] <= bus2.mem_req_addr;
    pv2[0] <= bus2.mem_read_en;
    for (int i = 1; i < L; i++) begin
      pa1[i] <= pa1[i-1]; pv1[i] <= pv1[i-1];
      pa2[i] <= pa2[i-1]; pv2[i] <= pv2[i-1];
    end
    bus1.mem_resp_data <= pv1[L-1] ? word_at(pa1[L-1]) : DW'($urandom);
    bus2.mem_resp_data <= pv2[L-1] ? {word_at(pa2[L-1] + AW'(2)), word_at(pa2[L-1])} : $urandom;
  end

  // ---------------- monitors ----------------
  logic [AW-1:0] rd_addr1[$], rd_addr2[$];
  int            rd_cyc1[$], rd_cyc2[$];
  logic [63:0]   rows1[$], rows2[$];
  logic [IW-1:0] idx1[$], idx2[$];
  int done_cnt1 = 0, done_cnt2 = 0, busy_done_overlap = 0, dbl_rd = 0;
  logic prev_rd1 = 1'b0;

  always @(negedge clk) begin
    if (bus1.mem_read_en) begin rd_addr1.push_back(bus1.mem_req_addr); rd_cyc1.push_back(cyc); end
    if (bus2.mem_read_en) begin rd_addr2.push_back(bus2.mem_req_addr); rd_cyc2.push_back(cyc); end
    if (bus1.row_valid && bus1.row_ready) begin rows1.push_back(bus1.row_data); idx1.push_back(bus1.row_idx); end
    if (bus2.row_valid && bus2.row_ready) begin rows2.push_back(bus2.row_data); idx2.push_back(bus2.row_idx); end
    if (done === 1'b1) done_cnt1 <= done_cnt1 + 1;
    if (done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
    if ((done && busy) || (done2 && busy2)) busy_done_overlap <= busy_done_overlap + 1;
    if (bus1.mem_read_en && prev_rd1) dbl_rd <= dbl_rd + 1;
    prev_rd1 <= bus1.mem_read_en;
  end

  // ---------------- row_ready driver ----------------
  int   ready_mode  = 0;
  logic ready_force = 1'b1;
  initial begin
    bus1.row_ready = 1'b1;
    bus2.row_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus1.row_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference row: element c of row r is the element index base_word + r*N + c.
  function automatic logic [63:0] exp_row(input int base_word, input int r);
    logic [63:0] v = '0;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'(base_word + r*N + c);
    return v;
  endfunction

  task automatic verify(input string tag, input int base, input int bf,
                        input logic [AW-1:0] addrs[$], input int cycs[$],
                        input logic [63:0] rows[$], input logic [IW-1:0] idxs[$]);
    int nb  = N * N / bf;
    int bpr = N / bf;
    logic [63:0] exp_q[$];
    check({tag, " reads"}, addrs.size(), nb);
    for (int i = 0; i < addrs.size() && i < nb; i++) begin
      check({tag, " addr"}, addrs[i], (base + i * bf * 2) % (1 << AW));
      if (i % bpr != 0) check({tag, " gap"}, cycs[i] - cycs[i-1], L + 2);
    end
    for (int r = 0; r < N; r++) exp_q.push_back(exp_row(base / 2, r));
    check({tag, " rows"}, rows.size(), N);
    for (int r = 0; r < rows.size() && r < N; r++) begin
      check({tag, " row"}, rows[r], exp_q.pop_front());
      check({tag, " idx"}, idxs[r], r);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rd_addr1.delete(); rd_cyc1.delete(); rows1.delete(); idx1.delete();
    rd_addr2.delete(); rd_cyc2.delete(); rows2.delete(); idx2.delete();
  endtask

  task automatic pulse_start(input logic s);
    @(posedge clk); #1;
    start = 1'b1; sel_x = s;
    @(posedge clk); #1;
    start = 1'b0; sel_x = 1'b0;
  endtask

  task automatic wait_done(input bit second, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((second ? done2 : done) === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit ok;
    int d0, rdn, bad, sel;
    logic [63:0] held_data;

    // reset state
    tick(3);
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst read_en", bus1.mem_read_en, 0);
    check("rst addr", bus1.mem_req_addr, 0);
    check("rst row_valid", bus1.row_valid, 0);
    check("rst row_data", bus1.row_data, 0);
    check("rst row_idx", bus1.row_idx, 0);
    check("rst write", {bus1.mem_write_en, bus1.mem_req_data}, 0);
    check("rst state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // scenario 1: W tile, always ready
    clear_q(); d0 = done_cnt1;
    pulse_start(1'b0);
    wait_done(1'b0, 500, ok);
    check("s1 done seen", ok, 1);
    tick(2);
    verify("s1", 0, 1, rd_addr1, rd_cyc1, rows1, idx1);
    check("s1 done count", done_cnt1 - d0, 1);
    check("s1 busy after", busy, 0);
`ifdef TILE_LOADER_PERF_EN
    check("s1 perf_stall", perf_stall1, 0);
    check("s1 perf_cycles", perf_cycles1, 68);
`endif

    // scenario 2: X tile
    clear_q();
    pulse_start(1'b1);
    wait_done(1'b0, 500, ok);
    check("s2 done seen", ok, 1);
    tick(2);
    verify("s2", 'h1000, 1, rd_addr1, rd_cyc1, rows1, idx1);

    // scenario 3: hold row 1 for 10 EMIT cycles
    clear_q();
    pulse_start(1'b0);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rows1.size() >= 1) begin ok = 1'b1; break; end
    end
    check("s3 row0 accepted", ok, 1);
    ready_force = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus1.row_valid === 1'b1) begin ok = 1'b1; break; end
    end
    check("s3 row1 valid", ok, 1);
    held_data = bus1.row_data;
    rdn = rd_addr1.size();
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (bus1.row_valid !== 1'b1 || bus1.row_data !== held_data || bus1.row_idx !== IW'(1)) bad++;
    end
    check("s3 hold idx", bus1.row_idx, 1);
    check("s3 hold data", held_data, exp_row(0, 1));
    check("s3 hold stable", bad, 0);
    check("s3 no reads in hold", rd_addr1.size(), rdn);
    check("s3 not accepted", rows1.size(), 1);
    ready_force = 1'b1;
    wait_done(1'b0, 500, ok);
    check("s3 done seen", ok, 1);
    tick(2);
    verify("s3", 0, 1, rd_addr1, rd_cyc1, rows1, idx1);
`ifdef TILE_LOADER_PERF_EN
    check("s3 perf_stall", perf_stall1, 10);
    check("s3 perf_cycles", perf_cycles1, 78);
`endif

    // scenario 4: BF=2 instance
    clear_q(); d0 = done_cnt2;
    @(posedge clk); #1; start2 = 1'b1; sel2 = 1'b0;
    @(posedge clk); #1; start2 = 1'b0;
    wait_done(1'b1, 500, ok);
    check("s4 done seen", ok, 1);
    tick(2);
    verify("s4", 0, 2, rd_addr2, rd_cyc2, rows2, idx2);
    check("s4 done count", done_cnt2 - d0, 1);

    // scenario 5: reset during WAIT of beat 5
    clear_q();
    pulse_start(1'b0);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus1.mem_read_en === 1'b1 && bus1.mem_req_addr === AW'('h00A)) begin ok = 1'b1; break; end
    end
    check("s5 beat5 issued", ok, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    d0 = done_cnt1;
    @(negedge clk);
    check("s5 in wait", dbg_state, ST_WAIT);
    @(negedge clk);
    check("s5 busy", busy, 0);
    check("s5 done", done, 0);
    check("s5 read_en", bus1.mem_read_en, 0);
    check("s5 addr", bus1.mem_req_addr, 0);
    check("s5 row_valid", bus1.row_valid, 0);
    check("s5 row_data", bus1.row_data, 0);
    check("s5 row_idx", bus1.row_idx, 0);
    check("s5 state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(10);
    check("s5 no done", done_cnt1 - d0, 0);
    clear_q();
    pulse_start(1'b0);
    wait_done(1'b0, 500, ok);
    check("s5 restart done", ok, 1);
    tick(2);
    check("s5 restart row0", (rows1.size() > 0) ? rows1[0] : 64'hx, exp_row(0, 0));
    verify("s5", 0, 1, rd_addr1, rd_cyc1, rows1, idx1);

    // scenario 6: start while busy and in the DONE cycle
    clear_q(); d0 = done_cnt1;
    pulse_start(1'b0);
    rdn = 0;
    for (int k = 0; k < 200 && rdn < 2; k++) begin
      @(negedge clk);
      if (bus1.mem_read_en === 1'b1) rdn++;
    end
    @(posedge clk); #1;
    start = 1'b1; sel_x = 1'b1;
    wait_done(1'b0, 500, ok);
    check("s6 done seen", ok, 1);
    @(posedge clk); #1;
    start = 1'b0; sel_x = 1'b0;
    tick(30);
    @(negedge clk);
    check("s6 busy", busy, 0);
    check("s6 idle", dbg_state, ST_IDLE);
    check("s6 done count", done_cnt1 - d0, 1);
    verify("s6", 0, 1, rd_addr1, rd_cyc1, rows1, idx1);

    // random loads with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      sel = int'($urandom_range(0, 1));
      clear_q();
      pulse_start(1'(sel));
      wait_done(1'b0, 3000, ok);
      check("rnd done seen", ok, 1);
      tick(2);
      verify("rnd", (sel != 0) ? 'h1000 : 0, 1, rd_addr1, rd_cyc1, rows1, idx1);
    end
    ready_mode = 0;
    tick(2);

    check("done with busy", busy_done_overlap, 0);
    check("read_en width", dbl_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog");
  end

endmodule
